nibble_mem_arbiter: RTL and testbench
=====================================

// Module: nibble_mem_arbiter
// PURPOSE
//  Shares the single write port of the 40-bit nibble memory between two requesters:
//  req 0 = front-panel editor, req 1 = bulk loader. Each request is one nibble write.
//  Performs read-modify-write: merges the new nibble into the current memory word and
//  pulses the memory write enable. Sits between the requesters and the Memory instance.
// PARAMETERS
//  NIBBLES  10  number of 4-bit cells in memory (memory width = 4*NIBBLES)
//  ADDR_W   4   nibble address width; addresses >= NIBBLES are illegal
// PORTS
//  clk       in   1          system clock (CLOCK_50 domain)
//  reset_n   in   1          asynchronous, active-low reset
//  hold      in   1          1 = block new grants (memory-reset mode)
//  req       in   2          per-requester request, held high until its ack
//  req_addr  in   2*ADDR_W   {addr1, addr0} nibble index
//  req_data  in   8          {data1, data0} nibble value
//  ack       out  2          one-cycle pulse, per requester: request completed
//  err       out  2          valid with ack: 1 = address out of range, no write done
//  busy      out  1          high while not IDLE
//  owner     out  1          index of requester being served (valid while busy)
//  mem_rd    in   4*NIBBLES  current memory contents
//  mem_we    out  1          memory write enable
//  mem_wr    out  4*NIBBLES  word to write: mem_rd with target nibble replaced
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, err=0, busy=0, owner=0, mem_we=0, rr_last=1.
//  FSM IDLE -> WRITE -> ACK -> IDLE; IDLE -> ACK directly on an illegal address.
//  IDLE (cycle T): if !hold and any req: choose winner, latch idx/addr/data, busy=1 from T+1.
//   Both requesting: winner = requester != rr_last (round robin). One requesting: it wins.
//   addr < NIBBLES -> WRITE; otherwise -> ACK with err latched to 1.
//  WRITE (T+1): mem_we=1 (decoded from state); mem_wr = mem_rd with bits
//   [4*addr+3:4*addr] = data; all other nibbles unchanged. Memory updates at end of T+1.
//  ACK (T+2): ack[owner]=1, err[owner]=latched err; rr_last <= owner; next state IDLE.
//  Total latency req->ack: 2 cycles legal, 1 cycle illegal. Max one write per 3 cycles.
//  Handshake: requester drops req on the edge where it samples ack; a req still high in
//   IDLE after ack is treated as a new request.
//  req dropped mid-operation: operation still completes and ack still pulses.
//  hold: checked only in IDLE; an operation in flight always completes; pending reqs wait.
//  reset_n low mid-operation: immediate return to reset values; no write, no ack.
//  mem_we=0 in all states except WRITE; mem_wr = mem_rd when mem_we=0.
// CONFIGURATION
//  ARB_STATS_EN defined: adds output conflicts [7:0]; increments (saturating at 255)
//   on every IDLE grant where both req bits are high; cleared by reset_n only.
//  ARB_STATS_EN undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package nibble_mem_pkg: NIBBLES, ADDR_W defaults, state encoding
//   (IDLE/WRITE/ACK), requester index constants REQ_EDIT=0, REQ_LOAD=1.
//  Sub-module nibble_merge: combinational (word, addr, data) -> word with nibble replaced;
//   reused by the editor.
// TESTING
//  Single write: mem=0, req0 addr=3 data=A -> mem_we at T+1, mem=0x0000_00A0_00, ack[0] at T+2.
//  Contention: req0 and req1 together from reset -> req0 served first, req1 acked 3 cycles later.
//  Fairness: both held continuously for 6 ops -> grants alternate 0,1,0,1,0,1.
//  Illegal addr: req1 addr=12 -> ack[1]&err[1] at T+1, mem_we never asserted, mem unchanged.
//  Hold: hold=1 with req0 pending -> no grant for 10 cycles; hold=0 -> ack[0] 2 cycles later.
//  Reset mid-op: reset_n low in WRITE cycle -> mem_we=0 and no ack; outputs at reset values.

Source files
------------

// File: rtl/nibble_mem_pkg.sv
// Shared definitions for the nibble memory write path.
//  NIBBLES_DEF / ADDR_W_DEF : default memory geometry (10 nibbles, 4-bit index)
//  state_t                  : arbiter FSM encoding (IDLE / WRITE / ACK)
//  REQ_EDIT / REQ_LOAD      : requester indices (front-panel editor, bulk loader)
package nibble_mem_pkg;

  localparam int NIBBLES_DEF = 10;
  localparam int ADDR_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic REQ_EDIT = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/nibble_merge.sv
// Combinational nibble replace: returns word with nibble [addr] set to data.
// An addr outside 0..NIBBLES-1 returns word unchanged.
//  word   in  4*NIBBLES  current memory word
//  addr   in  ADDR_W     nibble index
//  data   in  4          new nibble value
//  merged out 4*NIBBLES  word with the addressed nibble replaced
module nibble_merge
  import nibble_mem_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic [4*NIBBLES-1:0] word,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [3:0]           data,
  output logic [4*NIBBLES-1:0] merged
);

  always_comb begin
    // NOTE: the default assignment first means every path writes merged, so no latch is inferred.
    merged = word;
    for (int i = 0; i < NIBBLES; i++) begin
      if (addr == ADDR_W'(i)) merged[4*i +: 4] = data;
    end
  end

endmodule

// File: rtl/nibble_mem_arbiter.sv
// Two-requester arbiter for the single write port of the nibble memory.
// Each granted request is a read-modify-write of one nibble:
//   IDLE -> WRITE -> ACK -> IDLE (legal address), IDLE -> ACK (illegal address).
// Both requesting: round robin against the last served requester.
// Optional feature (macro ARB_STATS_EN): conflicts counter output.
//  clk, reset_n    clock, asynchronous active-low reset
//  hold            block new grants while high (checked in IDLE only)
//  req             per-requester request, held until ack
//  req_addr        {addr1, addr0} nibble index
//  req_data        {data1, data0} nibble value
//  ack, err        one-cycle completion pulse / out-of-range flag per requester
//  busy, owner     FSM not idle / requester currently served
//  mem_rd          current memory word
//  mem_we, mem_wr  memory write enable and merged word
//  conflicts       (ARB_STATS_EN) saturating count of grants with both requesting
module nibble_mem_arbiter
  import nibble_mem_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hold,
  input  logic [1:0]            req,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [7:0]            req_data,
  output logic [1:0]            ack,
  output logic [1:0]            err,
  output logic                  busy,
  output logic                  owner,
  input  logic [4*NIBBLES-1:0]  mem_rd,
  output logic                  mem_we,
  output logic [4*NIBBLES-1:0]  mem_wr
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]            conflicts
`endif
);

  localparam logic [ADDR_W:0] NIB_LIMIT = (ADDR_W+1)'(NIBBLES);

  state_t              state;
  logic                rr_last;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          data_q;

  logic                grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [3:0]          sel_data;
  logic                grant;
  logic [4*NIBBLES-1:0] merged;

  // Winner selection: contention goes to the requester not served last.
  always_comb begin
    grant_idx = REQ_EDIT;
    if (req == 2'b11)  grant_idx = ~rr_last;
    else if (req[REQ_LOAD]) grant_idx = REQ_LOAD;
    sel_addr = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_data = grant_idx ? req_data[7:4] : req_data[3:0];
  end

  assign grant = (state == IDLE) && !hold && (|req);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the latched address/data are reset too, so owner/mem_wr are deterministic after reset.
    if (!reset_n) begin
      state   <= IDLE;
      rr_last <= REQ_LOAD;
      owner   <= REQ_EDIT;
      addr_q  <= '0;
      data_q  <= '0;
      ack     <= '0;
      err     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop update based on pre-edge values.
      ack <= '0;
      err <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner  <= grant_idx;
            addr_q <= sel_addr;
            data_q <= sel_data;
            if ({1'b0, sel_addr} < NIB_LIMIT) begin
              state <= WRITE;
            end else begin
              // Illegal address: skip the write and acknowledge next cycle with err.
              state          <= ACK;
              ack[grant_idx] <= 1'b1;
              err[grant_idx] <= 1'b1;
            end
          end
        end
        WRITE: begin
          state      <= ACK;
          ack[owner] <= 1'b1;
        end
        ACK: begin
          rr_last <= owner;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nibble_merge #(.NIBBLES(NIBBLES), .ADDR_W(ADDR_W)) u_merge (
    .word   (mem_rd),
    .addr   (addr_q),
    .data   (data_q),
    .merged (merged)
  );

  assign busy   = (state != IDLE);
  assign mem_we = (state == WRITE);
  assign mem_wr = mem_we ? merged : mem_rd;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 conflicts <= '0;
    else if (grant && req == 2'b11 && conflicts != 8'hFF) conflicts <= conflicts + 8'd1;
  end
`endif

endmodule

// File: tb/tb_nibble_mem_arbiter.sv
// Directed bench for nibble_mem_arbiter with a behavioural memory attached.
module tb_nibble_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        hold;
  logic [1:0]  req;
  logic [7:0]  req_addr;
  logic [7:0]  req_data;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic        busy;
  logic        owner;
  logic [39:0] mem = '0;
  logic        mem_we;
  logic [39:0] mem_wr;
`ifdef ARB_STATS_EN
  logic [7:0]  conflicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nibble_mem_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .owner    (owner),
    .mem_rd   (mem),
    .mem_we   (mem_we),
    .mem_wr   (mem_wr)
`ifdef ARB_STATS_EN
    ,
    .conflicts(conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: not touched by reset_n.
  always @(posedge clk) if (mem_we) mem <= mem_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; hold = 1'b0; req = 2'b00; req_addr = '0; req_data = '0;
    step(); step();
    check("rst_ack",   ack,    2'b00);
    check("rst_err",   err,    2'b00);
    check("rst_busy",  busy,   1'b0);
    check("rst_owner", owner,  1'b0);
    check("rst_we",    mem_we, 1'b0);
    check("rst_wr",    mem_wr, 40'h0);
    reset_n = 1'b1;
    step();

    // Single write: req0 addr 3 data A
    req = 2'b01; req_addr = {4'd0, 4'd3}; req_data = {4'h0, 4'hA};
    step();
    check("sw_we",    mem_we, 1'b1);
    check("sw_busy",  busy,   1'b1);
    check("sw_owner", owner,  1'b0);
    check("sw_ack0",  ack,    2'b00);
    check("sw_wr",    mem_wr, 40'h000000A000);
    step();
    check("sw_ack",   ack,    2'b01);
    check("sw_err",   err,    2'b00);
    check("sw_we2",   mem_we, 1'b0);
    check("sw_mem",   mem,    40'h000000A000);
    req = 2'b00;
    step();
    check("sw_ackclr", ack,  2'b00);
    check("sw_idle",   busy, 1'b0);

    // Illegal address: req1 addr 12
    req = 2'b10; req_addr = {4'd12, 4'd0}; req_data = {4'h5, 4'h0};
    step();
    check("il_ack",   ack,    2'b10);
    check("il_err",   err,    2'b10);
    check("il_we",    mem_we, 1'b0);
    check("il_owner", owner,  1'b1);
    req = 2'b00;
    step();
    check("il_ackclr", ack,  2'b00);
    check("il_idle",   busy, 1'b0);
    check("il_mem",    mem,  40'h000000A000);

    // Contention: last served was 1, so 0 wins, 1 follows three cycles later
    req = 2'b11; req_addr = {4'd9, 4'd0}; req_data = {4'hF, 4'h1};
    step();
    check("ct_owner0", owner,  1'b0);
    check("ct_wr0",    mem_wr, 40'h000000A001);
    step();
    check("ct_ack0",   ack,    2'b01);
    req = 2'b10;
    step();
    check("ct_gap",    ack,    2'b00);
    step();
    check("ct_owner1", owner,  1'b1);
    check("ct_we1",    mem_we, 1'b1);
    step();
    check("ct_ack1",   ack,    2'b10);
    check("ct_mem",    mem,    40'hF00000A001);
    req = 2'b00;
    step();

    // Fairness: both held continuously for six operations
    req = 2'b11; req_addr = {4'd2, 4'd1}; req_data = {4'h3, 4'h2};
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("fr_owner%0d", k), owner, (k % 2 == 0) ? 1'b0 : 1'b1);
      step();
      check($sformatf("fr_ack%0d", k), ack, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 5) req = 2'b00;
      step();
    end
    check("fr_mem", mem, 40'hF00000A321);
`ifdef ARB_STATS_EN
    check("fr_conflicts", conflicts, 8'd7);
`endif

    // Hold blocks grants; release lets the pending request complete
    hold = 1'b1; req = 2'b01; req_addr = {4'd0, 4'd5}; req_data = {4'h0, 4'h7};
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("hd_busy%0d", k), {busy, mem_we, ack}, 4'b0000);
    end
    hold = 1'b0;
    step();
    check("hd_we",  mem_we, 1'b1);
    step();
    check("hd_ack", ack,    2'b01);
    check("hd_mem", mem,    40'hF00070A321);
    req = 2'b00;
    step();

    // Reset asserted during WRITE: no write, no ack
    req = 2'b01; req_addr = {4'd0, 4'd4}; req_data = {4'h0, 4'hC};
    step();
    check("rm_we_pre", mem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rm_we",    mem_we, 1'b0);
    check("rm_busy",  busy,   1'b0);
    check("rm_owner", owner,  1'b0);
    step();
    check("rm_ack",   ack,    2'b00);
    check("rm_mem",   mem,    40'hF00070A321);
    req = 2'b00;
    reset_n = 1'b1;
    step();
    check("rm_idle",  busy,   1'b0);

    // After reset the round-robin pointer favours requester 0 again
    req = 2'b11; req_addr = {4'd8, 4'd8}; req_data = {4'h6, 4'hB};
    step();
    check("rr_owner", owner, 1'b0);
    step();
    check("rr_ack",   ack,   2'b01);
    req = 2'b00;
    step();
    check("rr_mem",   mem,   40'hFB0070A321);
`ifdef ARB_STATS_EN
    check("rr_conflicts", conflicts, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
